// File: rtl/rs_dec_sched.sv
// rs_dec_sched: paces an upstream byte stream into a Reed-Solomon decoder that
// needs one CE pulse per input byte with a fixed idle gap between pulses,
// tracks how many codewords are inside the decoder, and reframes the decoder
// output into blocks with start/end markers.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   in_valid/in_data  upstream byte offer; in_ready = byte taken this cycle
//   dec_ce/dec_byte   one-clock CE pulse and held input byte to the decoder
//   dec_out/dec_ceo/dec_valid  decoder output byte and qualifiers
//   out_valid/out_data/out_sop/out_eop  decoded byte stream, 1-clock latency
//   inflight          codewords fully fed but not yet fully drained
//   err_unexp         sticky flag: decoder produced output with none in flight
module rs_dec_sched #(
  parameter int unsigned GAP          = 6,
  parameter int unsigned N_IN         = 204,
  parameter int unsigned N_OUT        = 188,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       dec_ce,
  output logic [7:0] dec_byte,
  input  logic [7:0] dec_out,
  input  logic       dec_ceo,
  input  logic       dec_valid,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic [2:0] inflight,
  output logic       err_unexp
);

  localparam int unsigned IN_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int unsigned OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_GAP, S_STALL} state_t;

  state_t           state;
  logic [7:0]       gap_cnt;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;

  logic       accept;
  logic       in_last;
  logic       fire;
  logic       expected;
  logic       blk_done;
  logic       cw_done;
  logic       credit;
  logic       credit_nxt;
  logic [2:0] inflight_nxt;

  assign accept   = in_valid && in_ready;
  assign in_last  = (in_cnt == IN_W'(N_IN - 1));
  assign fire     = dec_valid && dec_ceo;
  // Output bytes only count toward a block while a codeword is in flight.
  assign expected = fire && (inflight != 3'd0);
  assign blk_done = expected && (out_cnt == OUT_W'(N_OUT - 1));
  assign cw_done  = accept && in_last;

  always_comb begin
    inflight_nxt = inflight;
    if (cw_done && !blk_done) begin
      inflight_nxt = inflight + 3'd1;
    end else if (!cw_done && blk_done) begin
      inflight_nxt = inflight - 3'd1;
    end
  end

  // Credit only gates the first byte of a codeword.
  assign credit     = (in_cnt != '0) || (inflight < 3'(MAX_INFLIGHT));
  assign credit_nxt = (in_cnt != '0) || (inflight_nxt < 3'(MAX_INFLIGHT));
  assign in_ready   = !reset && (state == S_IDLE) && credit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      inflight  <= '0;
      dec_ce    <= 1'b0;
      dec_byte  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      dec_ce <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            dec_byte <= in_data;
            dec_ce   <= 1'b1;
            state    <= S_FEED;
          end
        end
        S_FEED: begin
          gap_cnt <= 8'(GAP);
          state   <= S_GAP;
        end
        S_GAP: begin
          // Leave on the cycle the count reaches zero, so GAP cycles are
          // spent here and the CE period is FEED + GAP + IDLE = GAP+2.
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) begin
            state <= credit_nxt ? S_IDLE : S_STALL;
          end
        end
        S_STALL: begin
          if (credit_nxt) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        in_cnt <= in_last ? '0 : in_cnt + IN_W'(1);
      end
      inflight <= inflight_nxt;

      out_valid <= fire;
      out_sop   <= expected && (out_cnt == '0);
      out_eop   <= blk_done;
      if (fire) begin
        out_data <= dec_out;
      end
      if (expected) begin
        out_cnt <= blk_done ? '0 : out_cnt + OUT_W'(1);
      end
      if (fire && (inflight == 3'd0)) begin
        err_unexp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs_dec_sched.sv
// tb_rs_dec_sched: directed bench for rs_dec_sched. A behavioural model
// (time since last accepted byte, byte counts modulo codeword/block sizes)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_rs_dec_sched;
  localparam int GAP   = 6;
  localparam int N_IN  = 204;
  localparam int N_OUT = 188;
  localparam int MAXI  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       dec_ce;
  logic [7:0] dec_byte;
  logic [7:0] dec_out;
  logic       dec_ceo;
  logic       dec_valid;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic [2:0] inflight;
  logic       err_unexp;

  always #5 clk = ~clk;

  rs_dec_sched #(.GAP(GAP), .N_IN(N_IN), .N_OUT(N_OUT), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dec_ce(dec_ce), .dec_byte(dec_byte),
    .dec_out(dec_out), .dec_ceo(dec_ceo), .dec_valid(dec_valid),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .inflight(inflight), .err_unexp(err_unexp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit         m_on = 1'b0;
  int         m_since, m_in_cnt, m_out_cnt, m_infl;
  logic       m_ce, m_out_valid, m_sop, m_eop, m_err;
  logic [7:0] m_dec_byte, m_out_data;
  bit         mb_acc, mb_inc, mb_dec, mb_fire;

  // A byte may be taken GAP+2 cycles after the previous one, and a new
  // codeword may only start while fewer than MAXI are in flight.
  function automatic bit m_ready();
    return (m_since >= GAP + 2) && ((m_in_cnt != 0) || (m_infl < MAXI));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1; m_since = 1000; m_in_cnt = 0; m_out_cnt = 0; m_infl = 0;
      m_ce = 1'b0; m_dec_byte = '0; m_out_valid = 1'b0; m_out_data = '0;
      m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0;
    end else if (m_on) begin
      mb_acc = in_valid && m_ready();
      mb_inc = 1'b0;
      mb_dec = 1'b0;
      m_ce = mb_acc;
      if (mb_acc) begin
        m_dec_byte = in_data;
        m_since = 1;
        m_in_cnt++;
        if (m_in_cnt == N_IN) begin m_in_cnt = 0; mb_inc = 1'b1; end
      end else if (m_since < 1000) m_since++;
      mb_fire = dec_valid && dec_ceo;
      m_out_valid = mb_fire;
      m_sop = 1'b0;
      m_eop = 1'b0;
      if (mb_fire) begin
        m_out_data = dec_out;
        if (m_infl > 0) begin
          m_sop = (m_out_cnt == 0);
          m_out_cnt++;
          if (m_out_cnt == N_OUT) begin m_out_cnt = 0; m_eop = 1'b1; mb_dec = 1'b1; end
        end else m_err = 1'b1;
      end
      m_infl = m_infl + int'(mb_inc) - int'(mb_dec);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("in_ready",  in_ready,  !reset && m_ready());
      check("dec_ce",    dec_ce,    m_ce);
      check("dec_byte",  dec_byte,  m_dec_byte);
      check("inflight",  inflight,  m_infl);
      check("out_valid", out_valid, m_out_valid);
      check("out_data",  out_data,  m_out_data);
      check("out_sop",   out_sop,   m_sop);
      check("out_eop",   out_eop,   m_eop);
      check("err_unexp", err_unexp, m_err);
    end
  end

  // ---------------- monitors ----------------
  int ce_count = 0, eop_count = 0, cyc = 0, last_ce = -1;
  bit chk_period = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (out_eop === 1'b1) eop_count++;
    if (dec_ce === 1'b1) begin
      if (chk_period && last_ce >= 0) check("ce_period", cyc - last_ce, GAP + 2);
      last_ce = chk_period ? cyc : -1;
      ce_count++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] next_byte;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic feed_n(input int n);
    bit rdy;
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = next_byte;
      w = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #2;
        w++;
      end while (!rdy && w < 2000);
      if (!rdy) begin
        check("feed_timeout", rdy, 1);
        in_valid = 1'b0;
        return;
      end
      next_byte = next_byte + 8'd1;
    end
    in_valid = 1'b0;
  endtask

  // Alternating cycles also present half-qualified outputs that must be ignored.
  task automatic dec_send(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      dec_valid = 1'b1; dec_ceo = 1'b1; dec_out = base + 8'(i);
      tick(1);
      dec_valid = (i % 2) == 0; dec_ceo = (i % 2) != 0; dec_out = 8'hA5;
      tick(1);
    end
    dec_valid = 1'b0; dec_ceo = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int base_ce, e0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    dec_out = '0; dec_ceo = 1'b0; dec_valid = 1'b0; next_byte = '0;
    tick(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_dec_byte", dec_byte, 0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    tick(1);

    // Continuous feed: two codewords fill the credit.
    base_ce = ce_count;
    chk_period = 1'b1;
    feed_n(204);
    check("inflight_cw1", inflight, 1);
    tick(1);
    check("ce_after_cw1", ce_count - base_ce, 204);
    feed_n(204);
    check("inflight_cw2", inflight, 2);
    chk_period = 1'b0;

    // Third codeword stalls at its first byte until a block drains.
    fork
      feed_n(203);
      begin
        tick(30);
        check("stall_ready", in_ready, 0);
        check("stall_inflight", inflight, 2);
        check("stall_ce", ce_count - base_ce, 408);
        e0 = eop_count;
        dec_send(188, 8'h40);
        tick(2);
        check("eop_block1", eop_count - e0, 1);
      end
    join
    tick(10);
    check("ce_611", ce_count - base_ce, 611);
    check("inflight_611", inflight, 1);

    // Last input byte of codeword 3 accepted in the same cycle as an eop.
    dec_send(187, 8'h80);
    tick(4);
    in_valid = 1'b1; in_data = next_byte;
    dec_valid = 1'b1; dec_ceo = 1'b1; dec_out = 8'hEE;
    check("r37_ready", in_ready, 1);
    tick(1);
    in_valid = 1'b0; dec_valid = 1'b0; dec_ceo = 1'b0;
    check("r37_inflight", inflight, 1);
    check("r37_ce", dec_ce, 1);
    check("r37_eop", out_eop, 1);
    check("r37_dec_byte", dec_byte, next_byte);
    check("r37_out_data", out_data, 8'hEE);
    next_byte = next_byte + 8'd1;
    tick(10);
    dec_send(188, 8'hC0);
    tick(2);
    check("drained_inflight", inflight, 0);
    check("no_err_yet", err_unexp, 0);

    // Unexpected decoder output with nothing in flight.
    dec_valid = 1'b1; dec_ceo = 1'b1; dec_out = 8'h5A;
    tick(1);
    dec_valid = 1'b0; dec_ceo = 1'b0;
    check("r38_valid", out_valid, 1);
    check("r38_data", out_data, 8'h5A);
    check("r38_sop", out_sop, 0);
    check("r38_err", err_unexp, 1);
    tick(5);
    check("r38_sticky", err_unexp, 1);
    check("r38_inflight", inflight, 0);

    // Reset during GAP aborts the partial codeword.
    next_byte = '0;
    feed_n(101);
    tick(3);
    reset = 1'b1;
    tick(1);
    check("r39_ce", dec_ce, 0);
    check("r39_dec_byte", dec_byte, 0);
    check("r39_err", err_unexp, 0);
    check("r39_ready_in_rst", in_ready, 0);
    reset = 1'b0;
    tick(1);
    check("r39_ce_after", dec_ce, 0);
    feed_n(103);
    tick(1);
    check("r39_partial_inflight", inflight, 0);
    feed_n(101);
    tick(1);
    check("r39_full_inflight", inflight, 1);
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_dec_sched.md
RS_DEC_SCHED -- requirements
Module: rs_dec_sched

Interface
REQ-001 Parameter GAP, default 6: idle clocks between decoder CE pulses; legal range 6..255; CE period is GAP+2 clocks.
REQ-002 Parameter N_IN, default 204: input bytes per codeword.
REQ-003 Parameter N_OUT, default 188: output bytes per decoded block.
REQ-004 Parameter MAX_INFLIGHT, default 2: codewords fed but not yet fully drained; legal range 1..7.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream byte available.
REQ-008 in_data  input  8  upstream byte.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 dec_ce  output  1  one-clock chip-enable pulse to decoder CE.
REQ-011 dec_byte  output  8  byte to decoder input_byte.
REQ-012 dec_out  input  8  decoder Out_byte.
REQ-013 dec_ceo  input  1  decoder CEO.
REQ-014 dec_valid  input  1  decoder Valid_out.
REQ-015 out_valid  output  1  one-clock pulse per decoded byte.
REQ-016 out_data  output  8  decoded byte.
REQ-017 out_sop  output  1  with out_valid on byte 0 of a block.
REQ-018 out_eop  output  1  with out_valid on byte N_OUT-1 of a block.
REQ-019 inflight  output  3  current in-flight codeword count.
REQ-020 err_unexp  output  1  sticky: decoder output seen with inflight==0.

Function
REQ-021 FSM states: IDLE, FEED, GAP, STALL.
- IDLE: in_ready=1 iff inflight<MAX_INFLIGHT; on in_valid&&in_ready, register in_data into dec_byte, go FEED.
- FEED: dec_ce=1 for exactly this clock; go GAP; GAP counter loaded with GAP.
- GAP: decrement counter; at 0 go IDLE if inflight<MAX_INFLIGHT (after this cycle's update), else STALL.
- STALL: in_ready=0; go IDLE when inflight<MAX_INFLIGHT.
REQ-022 in_ready SHALL be 0 in FEED, GAP, STALL; one byte accepted per CE period at most.
REQ-023 Minimum spacing: rising edges of dec_ce SHALL be at least GAP+2 clocks apart; exactly GAP+2 with in_valid held high and credit available.
REQ-024 dec_byte SHALL change only on input acceptance and SHALL hold stable from the FEED cycle through the following GAP cycles.
REQ-025 Input byte counter 0..N_IN-1, incremented per accepted byte; on acceptance at N_IN-1 wraps to 0 and inflight increments.
REQ-026 Credit check: the byte that starts a new codeword (counter==0) SHALL NOT be accepted when inflight==MAX_INFLIGHT; bytes within a started codeword are never stalled by credit.
REQ-027 Output path: when dec_valid&&dec_ceo, next clock out_valid=1, out_data=dec_out (1-clock latency); otherwise out_valid=0, out_data holds.
REQ-028 Output byte counter 0..N_OUT-1; out_sop at 0, out_eop at N_OUT-1; wraps to 0 after eop; inflight decrements on eop.
REQ-029 Simultaneous inflight increment and decrement in one cycle: inflight unchanged.
REQ-030 Decoder output with inflight==0: byte still forwarded, counters not decremented below 0, err_unexp set until reset.
REQ-031 in_valid deassertion mid-codeword: FSM waits in IDLE indefinitely; counters retain state.

Reset
REQ-032 On reset=1 at a rising edge: state=IDLE, GAP counter=0, both byte counters=0, inflight=0, dec_ce=0, dec_byte=0, out_valid=0, out_data=0, out_sop=0, out_eop=0, err_unexp=0; in_ready=0 during reset, 1 first cycle after.
REQ-033 Reset asserted mid-codeword or during GAP SHALL abort immediately; no dec_ce pulse in the cycle following reset.

Verification
REQ-034 Reset then in_valid held high, bytes 0x00,0x01,... -> dec_ce pulses exactly every 8 clocks (GAP=6), dec_byte equals accepted byte on each pulse, 204 pulses then inflight=1.
REQ-035 MAX_INFLIGHT=2, decoder silent, 3 codewords offered -> 408 bytes accepted, inflight=2, in_ready stays 0 at byte 408 until one out_eop occurs, then feeding resumes.
REQ-036 Decoder model returns 188 bytes per block -> out_sop on byte 0, out_eop on byte 187, out_data matches dec_out delayed 1 clock, inflight decrements on eop.
REQ-037 Input byte 203 accepted in the same cycle as out_eop with inflight=1 -> inflight remains 1.
REQ-038 dec_valid&&dec_ceo with inflight=0 -> out_valid pulse, err_unexp=1 and sticky until reset.
REQ-039 Reset asserted during GAP after byte 100 -> all outputs at reset values next clock; next accepted byte counted as byte 0 of a new codeword.
